multmod_arbiter: RTL

//  Round-robin arbiter that shares one multmod (255-bit modular multiplier, mod P25519) among NREQ clients.

---
 rtl/multmod_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/multmod_arbiter.sv
// multmod_arbiter: round-robin arbiter serialising NREQ clients onto one shared multmod
module multmod_arbiter #(
  parameter int N    = 255,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   c_req_valid,
  output logic [NREQ-1:0]   c_req_ready,
  input  logic [NREQ*N-1:0] c_X,
  input  logic [NREQ*N-1:0] c_Y,
  output logic [NREQ-1:0]   c_res_valid,
  input  logic [NREQ-1:0]   c_res_ready,
  output logic [N-1:0]      c_Z,
  output logic [NREQ-1:0]   c_busy,
  output logic [N-1:0]      m_X,
  output logic [N-1:0]      m_Y,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  input  logic              m_req_busy,
  input  logic              m_res_valid,
  output logic              m_res_ready,
  input  logic [N-1:0]      m_Z
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, owner_q, owner_d, pick, idx;
  logic [N-1:0] m_x_q, m_x_d, m_y_q, m_y_d, c_z_q, c_z_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d, busy_q, busy_d, res_valid_q, res_valid_d;
  logic m_res_ready_q, m_res_ready_d;
  logic unused_busy;
  assign unused_busy = m_req_busy;
  always_comb begin
    pick = ptr_q;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (c_req_valid[idx]) pick = idx;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    m_x_d = m_x_q;
    m_y_d = m_y_q;
    c_z_d = c_z_q;
    busy_d = busy_q;
    res_valid_d = res_valid_q;
    req_ready_d = '0;
    m_res_ready_d = 1'b0;
    case (state_q)
      IDLE: if (|c_req_valid) begin
        state_d = ISSUE;
        owner_d = pick;
        m_x_d = c_X[pick*N +: N];
        m_y_d = c_Y[pick*N +: N];
        req_ready_d = NREQ'(1) << pick;
        busy_d = NREQ'(1) << pick;
      end
      ISSUE: if (m_req_ready) state_d = WAIT;
      WAIT: if (m_res_valid) begin
        state_d = RESP;
        c_z_d = m_Z;
        m_res_ready_d = 1'b1;
        res_valid_d = NREQ'(1) << owner_q;
      end
      RESP: if (c_res_ready[owner_q]) begin
        state_d = IDLE;
        res_valid_d = '0;
        busy_d = '0;
        ptr_d = owner_q == IDW'(NREQ - 1) ? '0 : owner_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      m_x_q <= '0;
      m_y_q <= '0;
      c_z_q <= '0;
      busy_q <= '0;
      res_valid_q <= '0;
      req_ready_q <= '0;
      m_res_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      m_x_q <= m_x_d;
      m_y_q <= m_y_d;
      c_z_q <= c_z_d;
      busy_q <= busy_d;
      res_valid_q <= res_valid_d;
      req_ready_q <= req_ready_d;
      m_res_ready_q <= m_res_ready_d;
    end
  end
  assign c_req_ready = req_ready_q;
  assign c_res_valid = res_valid_q;
  assign c_busy = busy_q;
  assign c_Z = c_z_q;
  assign m_X = m_x_q;
  assign m_Y = m_y_q;
  assign m_req_valid = state_q == ISSUE;
  assign m_res_ready = m_res_ready_q;
endmodule
